// File: rtl/urv_iram_port_arbiter_pkg.sv
// Shared types and helpers for the IRAM port B arbiter.
// State encoding, requester indices and the address mask.
package urv_iram_port_arbiter_pkg;

  typedef enum logic {
    ST_SHARED = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned REQ_CPU  = 0;
  localparam int unsigned REQ_HOST = 1;

  // Keep word address bits inside the RAM; byte lane bits are zero.
  function automatic logic [31:0] addr_mask(input int unsigned size);
    logic [31:0] m;
    m = size - 1;
    return m & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/urv_iram_port_arbiter.sv
// Arbitrates IRAM port B between the CPU data bus and a host loader.
// Registered acks track the one-cycle RAM read latency.
module urv_iram_port_arbiter
  import urv_iram_port_arbiter_pkg::*;
#(
  parameter int unsigned g_size          = 65536,
  parameter int unsigned g_host_max_wait = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [3:0]  d_bwe_i,
  input  logic [31:0] d_data_i,
  output logic        d_gnt_o,
  output logic        d_ack_o,
  output logic [31:0] d_rdata_o,
  input  logic        h_req_i,
  input  logic        h_we_i,
  input  logic [31:0] h_addr_i,
  input  logic [3:0]  h_bwe_i,
  input  logic [31:0] h_data_i,
  output logic        h_gnt_o,
  output logic        h_ack_o,
  output logic [31:0] h_rdata_o,
  input  logic        h_lock_i,
  output logic        locked_o,
  output logic        enb_o,
  output logic        web_o,
  output logic [31:0] ab_o,
  output logic [3:0]  bweb_o,
  output logic [31:0] db_o,
  input  logic [31:0] qb_i
);

  localparam int CW =
    (g_host_max_wait > 0) ? $clog2(g_host_max_wait + 1) : 1;
  localparam logic [CW-1:0] MAX_W = CW'(g_host_max_wait);
  localparam logic [31:0] AMASK = addr_mask(g_size);

  arb_state_e    state_q;
  arb_state_e    state_d;
  logic [CW-1:0] wait_q;
  logic [CW-1:0] wait_d;
  logic [1:0]    gnt;

  always_comb begin
    gnt = 2'b00;
    unique case (state_q)
      ST_LOCKED: gnt[REQ_HOST] = h_req_i;
      default: begin
        gnt[REQ_HOST] = h_req_i & (~d_req_i | (wait_q == MAX_W));
        gnt[REQ_CPU]  = d_req_i & ~gnt[REQ_HOST];
      end
    endcase
  end

  assign d_gnt_o = gnt[REQ_CPU];
  assign h_gnt_o = gnt[REQ_HOST];
  assign enb_o   = |gnt;

  // Starvation counter only runs while the host is kept waiting.
  always_comb begin
    wait_d = wait_q;
    if (!h_req_i || h_gnt_o)
      wait_d = '0;
    else if (wait_q != MAX_W)
      wait_d = wait_q + 1'b1;
  end

  assign state_d = h_lock_i ? ST_LOCKED : ST_SHARED;

  always_comb begin
    web_o  = 1'b0;
    ab_o   = '0;
    bweb_o = '0;
    db_o   = '0;
    unique case (1'b1)
      d_gnt_o: begin
        web_o  = d_we_i;
        ab_o   = d_addr_i & AMASK;
        bweb_o = d_bwe_i;
        db_o   = d_data_i;
      end
      h_gnt_o: begin
        web_o  = h_we_i;
        ab_o   = h_addr_i & AMASK;
        bweb_o = h_bwe_i;
        db_o   = h_data_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_SHARED;
      wait_q  <= '0;
      d_ack_o <= 1'b0;
      h_ack_o <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      d_ack_o <= d_gnt_o;
      h_ack_o <= h_gnt_o;
    end
  end

  assign locked_o  = (state_q == ST_LOCKED);
  assign d_rdata_o = qb_i;
  assign h_rdata_o = qb_i;

endmodule

// File: doc/urv_iram_port_arbiter.md
Name: urv_iram_port_arbiter

Overview:
Shares IRAM port B between the CPU data-side bus and a host/debug loader port, so firmware can be loaded or inspected while the core runs or is held.
- Grants at most one requester per cycle and drives the IRAM port B signals from the granted requester.
- Returns a registered acknowledge one cycle after grant, matching the synchronous RAM read latency.
- Bounds host starvation with a wait counter; supports a host lock mode that excludes the CPU entirely.

Parameters:
g_size, 65536, IRAM size in bytes; power of two; word address bits [log2(g_size)-1:2] are forwarded, upper bits forced to 0.
g_host_max_wait, 8, consecutive host-waiting cycles before the host overrides CPU priority; 0 = host has strict priority.

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-high
d_req_i  in  1  CPU access request
d_we_i  in  1  CPU write (1) / read (0)
d_addr_i  in  32  CPU byte address
d_bwe_i  in  4  CPU byte write enables
d_data_i  in  32  CPU write data
d_gnt_o  out  1  CPU request accepted this cycle (combinational)
d_ack_o  out  1  CPU access complete; d_rdata_o valid (registered)
d_rdata_o  out  32  CPU read data
h_req_i, h_we_i, h_addr_i[32], h_bwe_i[4], h_data_i[32]  in  host request, same meaning as CPU set
h_gnt_o  out  1  host grant (combinational)
h_ack_o  out  1  host completion (registered)
h_rdata_o  out  32  host read data
h_lock_i  in  1  host requests exclusive ownership
locked_o  out  1  arbiter in LOCKED state
enb_o  out  1  IRAM port B enable
web_o  out  1  IRAM port B write
ab_o  out  32  IRAM port B byte address
bweb_o  out  4  IRAM port B byte enables
db_o  out  32  IRAM port B write data
qb_i  in  32  IRAM port B read data (1-cycle latency)

Behaviour:
- Clocking and reset: one clock clk_i. rst_i is asynchronous and active-high.
  - On reset: state SHARED, wait counter 0, d_ack_o = h_ack_o = 0, locked_o = 0.
  - With no requests, all RAM outputs are 0.
- Handshake:
  - Requester holds req and all fields stable until it sees gnt.
  - gnt is combinational in the same cycle that enb_o = 1.
  - ack pulses exactly one cycle after gnt, for reads and writes alike.
  - Back-to-back grants to the same requester are allowed; throughput is 1 access/cycle.
- RAM drive:
  - enb_o = d_gnt_o | h_gnt_o.
  - web_o, ab_o, bweb_o, db_o are taken from the granted requester; all 0 when idle.
  - ab_o[1:0] = 0; address bits at and above log2(g_size) are forced to 0, i.e. modulo wrap.
- Read data:
  - d_rdata_o = h_rdata_o = qb_i, unregistered pass-through.
  - Valid only while the matching ack is high.
  - A write ack carries don't-care data.
- Arbitration in SHARED:
  - Only one requester: it is granted.
  - Both requesting: CPU is granted unless wait counter == g_host_max_wait, then host is granted.
  - With g_host_max_wait = 0 the host always wins.
- Wait counter:
  - Width clog2(g_host_max_wait+1).
  - Increments each cycle h_req_i = 1 and h_gnt_o = 0; saturates at g_host_max_wait.
  - Clears on h_gnt_o or when h_req_i = 0.
- State machine:
  - SHARED -> LOCKED when h_lock_i = 1 at a clock edge.
  - LOCKED -> SHARED when h_lock_i = 0.
  - In LOCKED: d_gnt_o = 0 always; host is granted whenever it requests; locked_o = 1 (registered state).
  - The cycle where h_lock_i first rises is still arbitrated as SHARED.
  - An ack owed for an access granted before the transition is still delivered.
- Simultaneous events:
  - A grant and the lock transition in the same cycle: the grant completes normally.
  - A held d_req_i during LOCKED is serviced on the first SHARED cycle.
- Reset mid-operation: a pending ack is dropped (ack = 0 after reset); requesters must reissue.

Decomposition:
- Shared package: state encoding (SHARED, LOCKED), requester index constants (CPU = 0, HOST = 1), and the address-mask helper derived from g_size.
- No sub-module; the arbitration decision is a single combinational block plus registered ack/state/counter.

Test Plan:
- CPU read d_addr = 0x0000_0010 alone, RAM word 4 = 0xDEADBEEF -> d_gnt_o same cycle, ab_o = 0x10, web_o = 0; next cycle d_ack_o = 1, d_rdata_o = 0xDEADBEEF; h_ack_o = 0.
- Host write h_addr = 0x0001_0004 (g_size = 65536), h_bwe = 4'b0011, data 0x12345678 -> ab_o = 0x4 (wrapped), bweb_o = 0011; h_ack_o one cycle later.
- CPU requests continuously, host requests from cycle 0, g_host_max_wait = 8 -> host granted at cycle 8, counter clears, CPU regranted at cycle 9.
- h_lock_i raised while CPU streams reads -> the CPU access in the rising cycle is granted and acked; from the next cycle d_gnt_o = 0 and locked_o = 1; after h_lock_i drops, CPU is regranted the following cycle.
- rst_i asserted asynchronously between gnt and ack -> d_ack_o = 0 immediately; after release, outputs idle and counter = 0.
- g_host_max_wait = 0, both requesting every cycle -> host granted every cycle, CPU never granted until h_req_i = 0.
